// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin lock arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Width of a binary port index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/wrr_lock_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
interface wrr_lock_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WEIGHT_W  = 4
);
  import arb_pkg::*;

  localparam int unsigned ID_W = id_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]          req_i;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;
  logic                          done_i;
  logic [NUM_PORTS-1:0]          gnt_o;
  logic                          gnt_valid_o;
  logic [ID_W-1:0]               gnt_id_o;

  modport master (output req_i, weight_i, done_i, input gnt_o, gnt_valid_o, gnt_id_o);
  modport slave  (input req_i, weight_i, done_i, output gnt_o, gnt_valid_o, gnt_id_o);
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request at or after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_W      = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic                 found,
  output logic [ID_W-1:0]      index,
  output logic [NUM_PORTS-1:0] onehot
);

  int unsigned     k;
  logic [ID_W-1:0] kk;

  always_comb begin
    found  = 1'b0;
    index  = '0;
    onehot = '0;
    k      = 0;
    kk     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      k  = (32'(ptr) + i) % NUM_PORTS;
      kk = ID_W'(k);
      if (!found && req[kk]) begin
        found      = 1'b1;
        index      = kk;
        onehot[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter whose grant is locked until done_i, with per-port bursts.
module wrr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WEIGHT_W  = 4
) (
  input logic               clk,
  input logic               reset,
  wrr_lock_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = id_width(NUM_PORTS);
  localparam int unsigned CNT_W = WEIGHT_W + 1;

  arb_state_e           state;
  logic [ID_W-1:0]      ptr;
  logic [WEIGHT_W-1:0]  burst_cnt;
  logic [WEIGHT_W-1:0]  eff_weight;

  logic [ID_W-1:0]      next_ptr_c;
  logic [ID_W-1:0]      pick_ptr_c;
  logic                 pick_found_c;
  logic [ID_W-1:0]      pick_idx_c;
  logic [NUM_PORTS-1:0] pick_oh_c;
  logic [WEIGHT_W-1:0]  pick_w_c;
  logic [WEIGHT_W-1:0]  pick_eff_c;
  logic                 stay_c;

  // In GRANT the picker only matters on release, so it always sees the post-release pointer.
  always_comb begin
    next_ptr_c = (32'(bus.gnt_id_o) == NUM_PORTS - 1) ? '0 : bus.gnt_id_o + ID_W'(1);
    pick_ptr_c = (state == ARB_GRANT) ? next_ptr_c : ptr;
    pick_w_c   = bus.weight_i[32'(pick_idx_c) * WEIGHT_W +: WEIGHT_W];
    pick_eff_c = (pick_w_c == '0) ? WEIGHT_W'(1) : pick_w_c;
    stay_c     = ((CNT_W'(burst_cnt) + CNT_W'(1)) < CNT_W'(eff_weight)) &&
                 bus.req_i[bus.gnt_id_o];
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_pick (
    .req    (bus.req_i),
    .ptr    (pick_ptr_c),
    .found  (pick_found_c),
    .index  (pick_idx_c),
    .onehot (pick_oh_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ARB_IDLE;
      ptr             <= '0;
      burst_cnt       <= '0;
      eff_weight      <= '0;
      bus.gnt_o       <= '0;
      bus.gnt_valid_o <= 1'b0;
      bus.gnt_id_o    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found_c) begin
            state           <= ARB_GRANT;
            bus.gnt_o       <= pick_oh_c;
            bus.gnt_valid_o <= 1'b1;
            bus.gnt_id_o    <= pick_idx_c;
            eff_weight      <= pick_eff_c;
            burst_cnt       <= '0;
          end
        end
        ARB_GRANT: begin
          if (bus.done_i) begin
            if (stay_c) begin
              burst_cnt <= burst_cnt + WEIGHT_W'(1);
            end else begin
              ptr <= next_ptr_c;
              if (pick_found_c) begin
                bus.gnt_o    <= pick_oh_c;
                bus.gnt_id_o <= pick_idx_c;
                eff_weight   <= pick_eff_c;
                burst_cnt    <= '0;
              end else begin
                state           <= ARB_IDLE;
                bus.gnt_o       <= '0;
                bus.gnt_valid_o <= 1'b0;
              end
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
